// File: rtl/serial_tx_buff_pkg.sv
// serial_tx_buff_pkg
// Shared definitions for the serial link. The transmitter (serial_tx_buff) and
// the receiver side both import this package so the FSM encoding and the
// default frame width stay in one place.
//   NDATA_DEFAULT : default frame width in bits
//   tx_state_t    : serializer FSM states (IDLE, SHIFT)
package serial_tx_buff_pkg;

  localparam int NDATA_DEFAULT = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

endpackage : serial_tx_buff_pkg

// File: rtl/serial_tx_buff_piso.sv
// piso_reg
// Parallel-in / serial-out register. The load has priority over the shift.
// Shifting is to the left with zero fill, so the serial bit is q[W-1].
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous clear, active low
//   ld  : parallel load of d
//   sh  : shift left by one
//   d   : parallel data in
//   q   : register contents
module piso_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         sh,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (sh) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

endmodule : piso_reg

// File: rtl/serial_tx_buff.sv
// serial_tx_buff
// Double-buffered parallel-to-serial transmitter. One frame can wait in a
// holding register while the previous frame shifts out, so consecutive frames
// leave back to back without idle bits. Data goes out MSB first, one bit per
// clk with ena=1.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active low
//   din    : parallel frame to transmit
//   load   : din valid (write strobe)
//   ready  : holding register empty, load will be accepted
//   ena    : bit strobe, one serial bit advances per clk with ena=1
//   dout   : serial data (0 while idle)
//   cntout : index of the bit currently on dout, 0 = MSB
//   busy   : a frame is being shifted (FSM is in SHIFT)
//   done   : one-cycle pulse after the final bit of a frame is consumed
//
// Handshake: a frame is transferred on a rising clk edge where load=1 and
// ready=1. ready depends only on internal state (never on load), and a load
// presented while ready=0 is dropped, not held off.
module serial_tx_buff
  import serial_tx_buff_pkg::*;
#(
  parameter  int NDATA     = NDATA_DEFAULT,
  localparam int NDATA_LOG = $clog2(NDATA)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NDATA-1:0]     din,
  input  logic                 load,
  output logic                 ready,
  input  logic                 ena,
  output logic                 dout,
  output logic [NDATA_LOG-1:0] cntout,
  output logic                 busy,
  output logic                 done
);

  localparam logic [NDATA_LOG-1:0] CNT_LAST = NDATA_LOG'(NDATA - 1);

  tx_state_t            state_q, state_d;
  logic [NDATA_LOG-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [NDATA-1:0]     hold_q;
  logic                 hold_valid;
  logic                 hold_take;
  logic                 load_acc;
  logic                 piso_ld, piso_sh;
  logic [NDATA-1:0]     shift_q;

  // Holding register. A capture and a take can never coincide: capture needs
  // hold_valid=0, take needs hold_valid=1.
  assign ready    = !hold_valid;
  assign load_acc = load && !hold_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (load_acc) begin
      hold_q     <= din;
      hold_valid <= 1'b1;
    end else if (hold_take) begin
      hold_valid <= 1'b0;
    end
  end

  // FSM state, bit counter and done pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    piso_ld   = 1'b0;
    piso_sh   = 1'b0;
    hold_take = 1'b0;
    case (state_q)
      IDLE: begin
        // ena is irrelevant here; a pending frame starts on its own.
        if (hold_valid) begin
          piso_ld   = 1'b1;
          hold_take = 1'b1;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (ena) begin
          if (cnt_q == CNT_LAST) begin
            done_d = 1'b1;
            cnt_d  = '0;
            if (hold_valid) begin
              // Chain straight into the next frame: no idle bit in between.
              piso_ld   = 1'b1;
              hold_take = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            piso_sh = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  piso_reg #(
    .W (NDATA)
  ) u_piso (
    .clk (clk),
    .rst (rst),
    .ld  (piso_ld),
    .sh  (piso_sh),
    .d   (hold_q),
    .q   (shift_q)
  );

  assign busy   = (state_q == SHIFT);
  assign dout   = busy ? shift_q[NDATA-1] : 1'b0;
  assign cntout = cnt_q;
  assign done   = done_q;

endmodule : serial_tx_buff

// File: tb/tb_serial_tx_buff.sv
// tb_serial_tx_buff
// Bench for serial_tx_buff with NDATA=8. Accepted frames are expanded into
// {bit index, bit value} items in exp_q; the negedge monitor compares the
// item at the head of the queue against {cntout, dout} and pops it when ena=1.
module tb_serial_tx_buff;

  localparam int NDATA = 8;
  localparam int NLOG  = 3;

  logic            clk;
  logic            rst;
  logic [NDATA-1:0] din;
  logic            load;
  logic            ready;
  logic            ena;
  logic            dout;
  logic [NLOG-1:0] cntout;
  logic            busy;
  logic            done;

  logic [NLOG:0] exp_q[$];
  int  n_tests;
  int  n_fail;
  int  done_cnt;
  bit  done_pend;
  bit  was_busy;
  int  ena_mode;

  serial_tx_buff #(
    .NDATA (NDATA)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .load   (load),
    .ready  (ready),
    .ena    (ena),
    .dout   (dout),
    .cntout (cntout),
    .busy   (busy),
    .done   (done)
  );

  // Clock and ena generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ena_mode)
      0:       ena = 1'b0;
      1:       ena = 1'b1;
      2:       ena = ~ena;
      default: ena = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver: present one frame for a single cycle. acc says whether the
  // holding register is expected to be free, i.e. whether the frame is kept.
  task automatic send(input logic [NDATA-1:0] d, input bit acc);
    @(posedge clk);
    #1;
    chk("ready", ready, acc);
    din  = d;
    load = 1'b1;
    if (acc) begin
      for (int i = 0; i < NDATA; i++) begin
        exp_q.push_back({NLOG'(i), d[NDATA-1-i]});
      end
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    din  = NDATA'($urandom_range(0, 255));
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0 && !done_pend) ok = 1'b1;
    end
    if (!ok) chk("timeout_idle", 0, 1);
  endtask

  // Scoreboard / monitor
  always @(negedge clk) begin
    logic [NLOG:0] item;
    if (!rst) begin
      exp_q.delete();
      done_pend = 1'b0;
      was_busy  = 1'b0;
      chk("rst_dout", dout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", cntout, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", ready, 1);
    end else begin
      chk("done", done, done_pend);
      if (done) done_cnt++;
      done_pend = 1'b0;
      if (was_busy && exp_q.size() > 0) chk("nogap", busy, 1);
      if (busy) begin
        if (exp_q.size() == 0) begin
          chk("underflow", 0, 1);
        end else begin
          item = exp_q[0];
          chk("bit", {cntout, dout}, item);
          if (ena) begin
            void'(exp_q.pop_front());
            if (item[NLOG:1] == NLOG'(NDATA - 1)) done_pend = 1'b1;
          end
        end
      end else begin
        chk("idle_dout", dout, 0);
        chk("idle_cnt", cntout, 0);
      end
      was_busy = busy;
    end
  end

  initial begin
    int d0;
    bit hit;
    n_tests  = 0;
    n_fail   = 0;
    done_cnt = 0;
    done_pend = 1'b0;
    was_busy = 1'b0;
    ena_mode = 0;
    ena  = 1'b0;
    rst  = 1'b0;
    load = 1'b0;
    din  = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // ena=1 while idle with nothing loaded: nothing may come out
    ena_mode = 1;
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    chk("idle_ena_done", done_cnt - d0, 0);

    // Single frame, constant ena
    d0 = done_cnt;
    send(8'hA5, 1'b1);
    wait_idle(50);
    chk("single_done_cnt", done_cnt - d0, 1);

    // Back to back, plus a third load while the holding register is full
    d0 = done_cnt;
    send(8'hF0, 1'b1);
    send(8'h0F, 1'b1);
    send(8'h3C, 1'b0);
    wait_idle(80);
    chk("b2b_done_cnt", done_cnt - d0, 2);

    // Stall: ena alternates, every bit is held for two cycles
    ena_mode = 2;
    d0 = done_cnt;
    send(8'hC3, 1'b1);
    wait_idle(80);
    chk("stall_done_cnt", done_cnt - d0, 1);

    // Reset in the middle of a frame
    ena_mode = 1;
    d0 = done_cnt;
    send(8'h5A, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (busy && cntout == 3'd3) hit = 1'b1;
    end
    chk("reach_cnt3", hit, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    send(8'h81, 1'b1);
    wait_idle(50);
    chk("after_rst_done_cnt", done_cnt - d0, 1);

    // Random frames with random ena
    ena_mode = 3;
    for (int k = 0; k < 4; k++) begin
      d0 = done_cnt;
      send(NDATA'($urandom_range(0, 255)), 1'b1);
      wait_idle(200);
      chk("rand_done_cnt", done_cnt - d0, 1);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_tx_buff
